// File: rtl/div_unit_if.sv
// Operand/result bundle between the execute stage and the multi-cycle divider.
// The master side drives the request, the slave side (the divider) returns results.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic             cancel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_div, cancel, a, b,
        input  stall_req, busy, done, quotient, remainder
    );

    modport slave (
        input  start, signed_div, cancel, a, b,
        output stall_req, busy, done, quotient, remainder
    );
endinterface

// File: rtl/div_unit.sv
// Restoring 32-bit DIV/DIVU unit: one quotient bit per cycle on magnitudes,
// sign correction applied when the results are committed to the HI/LO outputs.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] dividendRaw_q, dividendRaw_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             negQuo_q, negQuo_d;
    logic             negRem_q, negRem_d;
    logic             divZero_q, divZero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            quo_q         <= '0;
            divisor_q     <= '0;
            dividendRaw_q <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            negQuo_q      <= 1'b0;
            negRem_q      <= 1'b0;
            divZero_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            divisor_q     <= divisor_d;
            dividendRaw_q <= dividendRaw_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            negQuo_q      <= negQuo_d;
            negRem_q      <= negRem_d;
            divZero_q     <= divZero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        divisor_d     = divisor_q;
        dividendRaw_d = dividendRaw_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        negQuo_d      = negQuo_q;
        negRem_d      = negRem_q;
        divZero_d     = divZero_q;
        done_d        = 1'b0;
        cnt_d         = cnt_q;

        accept  = (state_q == IDLE) && bus.start && !bus.cancel;
        aNeg    = bus.signed_div && bus.a[WIDTH-1];
        bNeg    = bus.signed_div && bus.b[WIDTH-1];
        // The dividend MSB enters the partial remainder; the quotient bit fills the vacated LSB.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_q};

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = DIV;
                    quo_d         = aNeg ? -bus.a : bus.a;
                    divisor_d     = bNeg ? -bus.b : bus.b;
                    rem_d         = '0;
                    cnt_d         = '0;
                    negQuo_d      = aNeg ^ bNeg;
                    negRem_d      = aNeg;
                    divZero_d     = (bus.b == '0);
                    dividendRaw_d = bus.a;
                end
            end
            DIV: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d     = IDLE;
                done_d      = 1'b1;
                quotient_d  = divZero_q ? '1 : (negQuo_q ? -quo_q : quo_q);
                remainder_d = divZero_q ? dividendRaw_q : (negRem_q ? -rem_q : rem_q);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush wins over everything, including a result about to be committed.
        if (bus.cancel) begin
            state_d     = IDLE;
            done_d      = 1'b0;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
        end

        busy_d = (state_d == DIV);
    end

    assign bus.stall_req = accept || (state_q == DIV);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed DIV/DIVU vectors, latency,
// cancel/restart/reset behaviour, with immediate assertions at each check.
module tb_div_unit;

    logic clk;
    logic rst;
    int   checks;
    int   passed;
    int   doneEdge;
    int   stallCnt;
    int   doneCnt;

    localparam int ACT_NONE    = 0;
    localparam int ACT_RESTART = 1;
    localparam int ACT_CANCEL  = 2;
    localparam int ACT_RESET   = 3;

    div_unit_if #(.WIDTH(32)) dif ();

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drives one division request at loop index 0 (the cycle before the
    // accepting edge, edge 0) and then runs a fixed window of 48 cycles,
    // optionally injecting a restart/cancel/reset at index actionAt.
    // Index i samples the cycle following edge i-1.
    task automatic applyStimulus(input logic sgn, input logic [31:0] aIn, input logic [31:0] bIn,
                                 input int action, input int actionAt,
                                 output int firstDone, output int stalls, output int dones);
        firstDone = -1;
        stalls    = 0;
        dones     = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            dif.start  = (i == 0) || (action == ACT_RESTART && i == actionAt);
            dif.cancel = (action == ACT_CANCEL && i == actionAt);
            rst        = (action == ACT_RESET && i == actionAt);
            if (i == 0) begin
                dif.signed_div = sgn;
                dif.a          = aIn;
                dif.b          = bIn;
            end else if (action == ACT_RESTART && i == actionAt) begin
                dif.signed_div = 1'b0;
                dif.a          = 32'd1;
                dif.b          = 32'd1;
            end else begin
                dif.signed_div = 1'($urandom_range(0, 1));
                dif.a          = $urandom;
                dif.b          = $urandom;
            end
            #1;
            if (action == ACT_RESET && i == actionAt) begin
                checkOutput("rst_async_busy", {31'd0, dif.busy}, 32'd0);
                checkOutput("rst_async_quo", dif.quotient, 32'd0);
                checkOutput("rst_async_rem", dif.remainder, 32'd0);
            end
            if (dif.stall_req) stalls++;
            if (dif.done) begin
                dones++;
                if (firstDone < 0) firstDone = i - 1;
            end
        end
        @(negedge clk);
        dif.start  = 1'b0;
        dif.cancel = 1'b0;
        rst        = 1'b0;
        #1;
    endtask

    initial begin
        checks         = 0;
        passed         = 0;
        rst            = 1'b1;
        dif.start      = 1'b0;
        dif.cancel     = 1'b0;
        dif.signed_div = 1'b0;
        dif.a          = '0;
        dif.b          = '0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, dif.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, dif.done}, 32'd0);
        checkOutput("reset_quo", dif.quotient, 32'd0);
        checkOutput("reset_rem", dif.remainder, 32'd0);
        checkOutput("reset_stall", {31'd0, dif.stall_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] DIVU 100/7 with latency");
        applyStimulus(1'b0, 32'd100, 32'd7, ACT_NONE, 0, doneEdge, stallCnt, doneCnt);
        checkOutput("t1_done_edge", doneEdge, 32'd33);
        checkOutput("t1_stall_cycles", stallCnt, 32'd33);
        checkOutput("t1_done_count", doneCnt, 32'd1);
        checkOutput("t1_quo", dif.quotient, 32'd14);
        checkOutput("t1_rem", dif.remainder, 32'd2);
        checkOutput("t1_idle_busy", {31'd0, dif.busy}, 32'd0);

        $display("[TB] signed DIV sign handling");
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, ACT_NONE, 0, doneEdge, stallCnt, doneCnt);
        checkOutput("t2a_quo", dif.quotient, 32'hFFFF_FFFD);
        checkOutput("t2a_rem", dif.remainder, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, ACT_NONE, 0, doneEdge, stallCnt, doneCnt);
        checkOutput("t2b_quo", dif.quotient, 32'hFFFF_FFFD);
        checkOutput("t2b_rem", dif.remainder, 32'd1);

        $display("[TB] overflow operands");
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, ACT_NONE, 0, doneEdge, stallCnt, doneCnt);
        checkOutput("t3_div_quo", dif.quotient, 32'h8000_0000);
        checkOutput("t3_div_rem", dif.remainder, 32'd0);
        applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, ACT_NONE, 0, doneEdge, stallCnt, doneCnt);
        checkOutput("t3_divu_quo", dif.quotient, 32'd0);
        checkOutput("t3_divu_rem", dif.remainder, 32'h8000_0000);

        $display("[TB] divide by zero");
        applyStimulus(1'b0, 32'h1234_5678, 32'd0, ACT_NONE, 0, doneEdge, stallCnt, doneCnt);
        checkOutput("t4_done_edge", doneEdge, 32'd33);
        checkOutput("t4_quo", dif.quotient, 32'hFFFF_FFFF);
        checkOutput("t4_rem", dif.remainder, 32'h1234_5678);
        applyStimulus(1'b1, 32'hFFFF_FFF0, 32'd0, ACT_NONE, 0, doneEdge, stallCnt, doneCnt);
        checkOutput("t4s_quo", dif.quotient, 32'hFFFF_FFFF);
        checkOutput("t4s_rem", dif.remainder, 32'hFFFF_FFF0);

        $display("[TB] cancel at iteration 10");
        applyStimulus(1'b0, 32'd50, 32'd5, ACT_CANCEL, 11, doneEdge, stallCnt, doneCnt);
        checkOutput("t5_cancel_dones", doneCnt, 32'd0);
        checkOutput("t5_cancel_stalls", stallCnt, 32'd12);
        checkOutput("t5_cancel_quo", dif.quotient, 32'hFFFF_FFFF);
        checkOutput("t5_cancel_rem", dif.remainder, 32'hFFFF_FFF0);
        applyStimulus(1'b0, 32'd9, 32'd4, ACT_NONE, 0, doneEdge, stallCnt, doneCnt);
        checkOutput("t5_after_quo", dif.quotient, 32'd2);
        checkOutput("t5_after_rem", dif.remainder, 32'd1);

        @(negedge clk);
        dif.start  = 1'b1;
        dif.cancel = 1'b1;
        dif.a      = 32'd20;
        dif.b      = 32'd3;
        #1;
        checkOutput("t5_startcancel_stall", {31'd0, dif.stall_req}, 32'd0);
        @(negedge clk);
        dif.start  = 1'b0;
        dif.cancel = 1'b0;
        #1;
        checkOutput("t5_startcancel_busy", {31'd0, dif.busy}, 32'd0);
        checkOutput("t5_startcancel_stall2", {31'd0, dif.stall_req}, 32'd0);

        $display("[TB] restart ignored, then reset mid-operation");
        applyStimulus(1'b0, 32'd100, 32'd7, ACT_RESTART, 5, doneEdge, stallCnt, doneCnt);
        checkOutput("t6_restart_edge", doneEdge, 32'd33);
        checkOutput("t6_restart_dones", doneCnt, 32'd1);
        checkOutput("t6_restart_quo", dif.quotient, 32'd14);
        checkOutput("t6_restart_rem", dif.remainder, 32'd2);
        applyStimulus(1'b0, 32'd100, 32'd7, ACT_RESET, 21, doneEdge, stallCnt, doneCnt);
        checkOutput("t6_reset_dones", doneCnt, 32'd0);
        checkOutput("t6_reset_busy", {31'd0, dif.busy}, 32'd0);
        checkOutput("t6_reset_quo", dif.quotient, 32'd0);
        checkOutput("t6_reset_rem", dif.remainder, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU.
- Sits in the execute stage beside the combinational ALU and receives the same operand buses (A = rs value, B = rt value).
- Produces quotient (LO) and remainder (HI) for the HI/LO register write in the next stage.
- Raises a stall request so the pipeline holds EX while the division is in flight.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a division. Sampled only in IDLE.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU. Sampled with start.
- cancel  input  1  pipeline flush/exception. Aborts any operation.
- a  input  WIDTH  dividend (rs). Sampled with start.
- b  input  WIDTH  divisor (rt). Sampled with start.
- stall_req  output  1  combinational request to freeze IF/ID/EX
- busy  output  1  registered. Operation in progress (state DIV).
- done  output  1  registered. One-cycle pulse when results become valid.
- quotient  output  WIDTH  LO value. Registered.
- remainder  output  WIDTH  HI value. Registered.

Behaviour:
- Reset values: state=IDLE; busy=0; done=0; quotient=0; remainder=0; counter=0. Reset mid-operation discards all work immediately; no done is produced.
- States and transitions:
  - IDLE: start=1 and cancel=0 -> DIV. Latches |a|, |b|, signed_div, sign(a), sign(b), b==0; clears the partial remainder; counter=0.
  - DIV: one restoring step per cycle. Shift {rem,quo} left 1, trial-subtract the divisor from rem, set quo LSB to 1 if the result is non-negative, otherwise restore. counter increments. After the step with counter==WIDTH-1 -> DONE.
  - DONE: quotient/remainder registers load the corrected results; done=1 for exactly this cycle -> IDLE.
  - cancel=1 in any state -> IDLE next edge. done stays 0; quotient/remainder outputs keep their previous values. cancel has priority over start in the same cycle.
- Latency: start sampled at edge 0; DIV occupies edges 1..32; done=1 during the cycle after edge 33. Outputs are stable from then until the next accepted start completes.
- stall_req = (state==IDLE & start & ~cancel) | (state==DIV). It is low in DONE, so EX advances in the cycle results are valid.
- busy = (state==DIV).
- start while not in IDLE: ignored. It does not restart or queue.
- Sign correction (signed_div=1):
  - Quotient is negated when sign(a) != sign(b).
  - Remainder is negated when sign(a)=1 (remainder takes the dividend's sign).
  - Absolute values use WIDTH-bit two's-complement negation. |0x80000000| = 0x80000000, interpreted as unsigned.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. This falls out of the rules above; no special case.
- Divide by zero: full latency, no exception. Outputs quotient=0xFFFFFFFF, remainder=a (original, uncorrected). Applies to both signed and unsigned.
- Operand inputs may change freely after the start cycle. Only the latched copies are used.

Test Plan:
1. DIVU a=100, b=7, start pulse -> stall_req=1 for 33 cycles; done pulses once at cycle 33; quotient=14, remainder=2; both hold afterwards.
2. DIV a=0xFFFFFFF9 (-7), b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Then DIV a=7, b=0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
3. DIV a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU with the same operands -> quotient=0, remainder=0x80000000.
4. DIVU a=0x12345678, b=0 -> quotient=0xFFFFFFFF, remainder=0x12345678, after the full 33-cycle latency.
5. Sequence:
   - Start DIVU 50/5; assert cancel at DIV iteration 10 -> IDLE next edge, no done; quotient/remainder keep the prior results.
   - Immediately start DIVU 9/4 -> quotient=2, remainder=1.
   - start+cancel in the same IDLE cycle -> not accepted; stall_req=0.
6. Start DIVU 100/7, pulse start again with 1/1 mid-DIV -> ignored; result 14/2. Separately, assert rst at iteration 20 -> all outputs 0 asynchronously, state IDLE, no done.
